// File: rtl/fc_obuf.sv
// fc_obuf -- output buffer of a fully-connected layer tile.
//
// Takes one crossbar partial-sum vector per input bit plane (LSB plane first)
// and shift-accumulates them into full-precision dot products. Each result is
// requantized to DATA_SIZE bits. The results leave over NUM_CHANNELS parallel
// channels as write-enable pulses into the next layer's input-buffer FIFOs.
// Elements drain highest index first, so element k lands at downstream FIFO
// index k.
//
// Optional feature macro: FC_OBUF_SAT_EN
//   defined   : a requantized value above 2^DATA_SIZE-1 saturates to all ones
//   undefined : plain truncation to the low DATA_SIZE bits
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   i_start  in   begin a pass (honoured in IDLE only)
//   i_valid  in   i_psum holds one bit plane (used in ACCUM only)
//   i_psum   in   [NUM_CHANNELS][FIFO_LENGTH] unsigned partial sums
//   i_stall  in   downstream cannot take a word this cycle
//   o_we     out  downstream FIFO write enable (registered)
//   o_data   out  [NUM_CHANNELS] one element per channel (registered, held)
//   o_busy   out  state is not IDLE
//   o_done   out  one-cycle pulse, pass complete (registered)
//   o_state  out  FSM state for debug: 0 IDLE, 1 ACCUM, 2 DRAIN, 3 DONE
//
// Handshake: there is no back-pressure on the input side. A plane is consumed
// on every rising edge where the FSM is in ACCUM and i_valid is high. On the
// output side a word is emitted on every rising edge where the FSM is in DRAIN
// and i_stall is low. The word is visible with o_we=1 in the following cycle.
module fc_obuf #(
  parameter int DATA_SIZE    = 8,
  parameter int XBAR_SIZE    = 128,
  parameter int NUM_CHANNELS = 2,
  parameter int FIFO_LENGTH  = 4,
  parameter int PSUM_WIDTH   = DATA_SIZE + $clog2(XBAR_SIZE),
  parameter int ACC_WIDTH    = 2 * DATA_SIZE + $clog2(XBAR_SIZE),
  parameter int OUT_SHIFT    = DATA_SIZE + $clog2(XBAR_SIZE)
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  i_start,
  input  logic                                                  i_valid,
  input  logic [NUM_CHANNELS-1:0][FIFO_LENGTH-1:0][PSUM_WIDTH-1:0] i_psum,
  input  logic                                                  i_stall,
  output logic                                                  o_we,
  output logic [NUM_CHANNELS-1:0][DATA_SIZE-1:0]                o_data,
  output logic                                                  o_busy,
  output logic                                                  o_done,
  output logic [1:0]                                            o_state
);

  localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam int ELEM_W = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_n;

  logic [BIT_W-1:0]  bit_cnt;
  logic [ELEM_W-1:0] elem_cnt;
  logic [NUM_CHANNELS-1:0][FIFO_LENGTH-1:0][ACC_WIDTH-1:0] acc;

  logic clr;
  logic acc_en;
  logic last_plane;
  logic emit;
  logic last_elem;

  // Requantize one accumulator to DATA_SIZE bits.
  function automatic logic [DATA_SIZE-1:0] quant(input logic [ACC_WIDTH-1:0] a);
    logic [DATA_SIZE-1:0] q_low;
    q_low = DATA_SIZE'(a >> OUT_SHIFT);
`ifdef FC_OBUF_SAT_EN
    // Any bit set above the DATA_SIZE window after the shift means overflow.
    if ((a >> (OUT_SHIFT + DATA_SIZE)) != '0) begin
      q_low = '1;
    end
`endif
    return q_low;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_n    = state;
    clr        = 1'b0;
    acc_en     = 1'b0;
    last_plane = (bit_cnt == BIT_W'(DATA_SIZE - 1));
    emit       = 1'b0;
    last_elem  = (elem_cnt == '0);
    case (state)
      IDLE: begin
        if (i_start) begin
          clr     = 1'b1;
          state_n = ACCUM;
        end
      end
      ACCUM: begin
        if (i_valid) begin
          acc_en = 1'b1;
          if (last_plane) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!i_stall) begin
          emit = 1'b1;
          if (last_elem) state_n = DONE;
        end
      end
      DONE: begin
        // The state stays in DONE until o_done has been shown for one cycle.
        // This keeps o_busy high while o_done is high.
        if (o_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      elem_cnt <= '0;
      acc      <= '0;
      o_we     <= 1'b0;
      o_data   <= '0;
      o_done   <= 1'b0;
    end else begin
      o_we   <= emit;
      o_done <= (state == DONE) && !o_done;

      if (clr) begin
        acc     <= '0;
        bit_cnt <= '0;
      end

      if (acc_en) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          for (int e = 0; e < FIFO_LENGTH; e++) begin
            acc[c][e] <= acc[c][e] + (ACC_WIDTH'(i_psum[c][e]) << bit_cnt);
          end
        end
        if (last_plane) begin
          bit_cnt  <= '0;
          elem_cnt <= ELEM_W'(FIFO_LENGTH - 1);
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (emit) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
          o_data[c] <= quant(acc[c][elem_cnt]);
        end
        if (!last_elem) elem_cnt <= elem_cnt - 1'b1;
      end
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_fc_obuf.sv
// tb_fc_obuf -- directed bench for fc_obuf.
// Three instances share one stimulus stream and differ only in OUT_SHIFT
// (4, 0, 8). Each drained word is compared against a small accumulate and
// requantize model of the planes the bench itself drove.
module tb_fc_obuf;

  localparam int DS = 8;
  localparam int NC = 2;
  localparam int FL = 4;
  localparam int PW = 15;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic i_valid = 1'b0;
  logic i_stall = 1'b0;
  logic [NC-1:0][FL-1:0][PW-1:0] i_psum = '0;

  logic                    we   [ND];
  logic [NC-1:0][DS-1:0]   dout [ND];
  logic                    busy [ND];
  logic                    done [ND];
  logic [1:0]              st   [ND];

  int shv [ND] = '{4, 0, 8};

  logic [PW-1:0] pl [DS][NC][FL];
  logic [15:0]   last_word [ND];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fc_obuf #(.OUT_SHIFT(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_psum(i_psum), .i_stall(i_stall), .o_we(we[0]), .o_data(dout[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_state(st[0]));

  fc_obuf #(.OUT_SHIFT(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_psum(i_psum), .i_stall(i_stall), .o_we(we[1]), .o_data(dout[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_state(st[1]));

  fc_obuf #(.OUT_SHIFT(8)) u_s8 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_valid(i_valid),
    .i_psum(i_psum), .i_stall(i_stall), .o_we(we[2]), .o_data(dout[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_state(st[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_word(input int sh, input int c, input int e);
    longint acc;
    longint q;
    acc = 0;
    for (int b = 0; b < DS; b++) acc += longint'(pl[b][c][e]) << b;
    q = acc >> sh;
`ifdef FC_OBUF_SAT_EN
    if (q > 255) return 8'hff;
`endif
    return q[7:0];
  endfunction

  function automatic logic [15:0] model_vec(input int d, input int e);
    return {model_word(shv[d], 1, e), model_word(shv[d], 0, e)};
  endfunction

  task automatic fill_all(input logic [PW-1:0] v);
    for (int b = 0; b < DS; b++)
      for (int c = 0; c < NC; c++)
        for (int e = 0; e < FL; e++) pl[b][c][e] = v;
  endtask

  task automatic fill_ramp();
    fill_all('0);
    for (int c = 0; c < NC; c++)
      for (int e = 0; e < FL; e++) pl[0][c][e] = PW'(e + 1);
  endtask

  task automatic drive_plane(input int b);
    for (int c = 0; c < NC; c++)
      for (int e = 0; e < FL; e++) i_psum[c][e] = pl[b][c][e];
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int d = 0; d < ND; d++) check("busy_after_start", 32'(busy[d]), 1);
  endtask

  // Full pass: start, DS planes with `gap` idle cycles before each plane,
  // then the drain with a per-edge stall mask (bit k = stall at drain edge k).
  task automatic run_pass(input int gap, input logic [39:0] stall_mask, input bit poke);
    int  w;
    bit  exp_we, exp_done, prev_last, prev_done, finished;
    if (poke) begin
      // Stray planes in IDLE must not start anything.
      i_valid = 1'b1;
      i_psum  = '1;
      @(negedge clk);
      i_valid = 1'b0;
      for (int d = 0; d < ND; d++) check("idle_valid_ignored", 32'(busy[d]), 0);
    end
    pulse_start();
    for (int b = 0; b < DS; b++) begin
      repeat (gap) @(negedge clk);
      drive_plane(b);
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
    end
    w = 0; prev_last = 0; prev_done = 0; finished = 0;
    for (int k = 1; k < 40 && !finished; k++) begin
      i_stall = stall_mask[k];
      if (poke) begin
        i_start = 1'b1;
        i_valid = 1'b1;
        i_psum  = '1;
      end
      @(negedge clk);
      exp_we   = !stall_mask[k] && (w < FL);
      exp_done = prev_last;
      for (int d = 0; d < ND; d++) begin
        check("o_we", 32'(we[d]), 32'(exp_we));
        check("o_done", 32'(done[d]), 32'(exp_done));
        check("o_busy", 32'(busy[d]), 32'(!prev_done));
        if (exp_we) begin
          check("o_data_word", 32'(dout[d]), 32'(model_vec(d, FL - 1 - w)));
          last_word[d] = model_vec(d, FL - 1 - w);
        end else begin
          check("o_data_hold", 32'(dout[d]), 32'(last_word[d]));
        end
      end
      if (prev_done) finished = 1;
      prev_last = exp_we && (w == FL - 1);
      prev_done = exp_done;
      if (exp_we) w++;
    end
    i_stall = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    if (!finished) check("drain_timeout", 0, 1);
    check("word_count", 32'(w), FL);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) last_word[d] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_we", 32'(we[d]), 0);
      check("rst_data", 32'(dout[d]), 0);
      check("rst_busy", 32'(busy[d]), 0);
      check("rst_done", 32'(done[d]), 0);
      check("rst_state", 32'(st[d]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Every psum 1 on all planes: acc=255, shift 4 -> 15
    fill_all(PW'(1));
    run_pass(0, '0, 0);
    check("t1_shift4_const", 32'(dout[0]), {8'd15, 8'd15});
    check("t1_shift0_const", 32'(dout[1]), {8'd255, 8'd255});

    // Ramp on plane 0 only, shift 0 -> 4,3,2,1; last word is element 0 = 1
    fill_ramp();
    run_pass(0, '0, 0);
    check("t2_shift0_last", 32'(dout[1]), {8'd1, 8'd1});

    // Large psums: q = 32512 at shift 8
    fill_all(PW'(32640));
    run_pass(0, '0, 0);
`ifdef FC_OBUF_SAT_EN
    check("t3_shift8_sat", 32'(dout[2]), {8'd255, 8'd255});
`else
    check("t3_shift8_trunc", 32'(dout[2]), {8'd0, 8'd0});
`endif

    // Stall for 3 edges after the 2nd word
    fill_all(PW'(1));
    run_pass(0, 40'h38, 0);
    check("t4_stall_const", 32'(dout[0]), {8'd15, 8'd15});

    // Mid-pass reset after 3 planes in ACCUM
    fill_all(PW'(3));
    pulse_start();
    for (int b = 0; b < 3; b++) begin
      drive_plane(b);
      i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("midrst_we", 32'(we[d]), 0);
      check("midrst_data", 32'(dout[d]), 0);
      check("midrst_busy", 32'(busy[d]), 0);
      check("midrst_done", 32'(done[d]), 0);
      last_word[d] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_all(PW'(1));
    run_pass(0, '0, 0);
    check("t5_no_residue", 32'(dout[0]), {8'd15, 8'd15});

    // Idle valid pokes, start/valid during drain and DONE, 2-cycle plane gaps
    fill_ramp();
    run_pass(2, '0, 1);
    check("t6_gap_last", 32'(dout[1]), {8'd1, 8'd1});
    @(negedge clk);
    for (int d = 0; d < ND; d++) check("t6_stays_idle", 32'(busy[d]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
